// File: rtl/sram_d_obi_arbiter.sv
// -----------------------------------------------------------------------------
// sram_d_obi_arbiter
//
// Two-master OBI arbiter for the single SRAM data port (sram_d) of the SoC SRAM
// wrapper. Master 0 is the core LSU data port and master 1 is the debug/DMA
// port. At most one winner is forwarded per cycle. An in-order ID FIFO records
// who was granted so that rvalid/rdata are routed back to the issuer.
// Requests outside [SRAM_BASE_ADDR, SRAM_END_ADDR) are not forwarded. They are
// granted locally and answered with an error response carrying 32'hDEAD_BEEF.
//
// Build option:
//   OBI_ARB_RR_EN  defined   -> round-robin. After a grant, priority moves to
//                               the other master.
//                  undefined -> fixed priority. Master 0 wins contention.
//
// Ports:
//   clk_i, rst_ni                  clock and asynchronous active-low reset
//   m{0,1}_req_i/_gnt_o            master request / grant (grant is combinational)
//   m{0,1}_addr_i/_we_i/_be_i/_wdata_i   master address phase
//   m{0,1}_rvalid_o/_rdata_o/_err_o      master response phase (combinational)
//   s_req_o/s_gnt_i/s_addr_o/s_we_o/s_be_o/s_wdata_o   downstream address phase
//   s_rvalid_i/s_rdata_i           downstream response phase
//   illegal_memory_o               high in the cycle an out-of-window request is granted
//
// Handshake: an address phase transfers in the cycle where req and gnt are both
// high. The requester holds req and its address-phase fields stable until that
// cycle. The response phase has no back-pressure. rvalid is a one-cycle
// strobe, and rdata/err are meaningful only while rvalid is high. Responses
// return in grant order.
// -----------------------------------------------------------------------------
module sram_d_obi_arbiter #(
  parameter logic [31:0] SRAM_BASE_ADDR  = 32'h8000_0000,
  parameter logic [31:0] SRAM_END_ADDR   = 32'h8000_C000,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // master 0 (core LSU)
  input  logic        m0_req_i,
  output logic        m0_gnt_o,
  input  logic [31:0] m0_addr_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,
  // master 1 (debug / DMA)
  input  logic        m1_req_i,
  output logic        m1_gnt_o,
  input  logic [31:0] m1_addr_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,
  // downstream sram_d port
  output logic        s_req_o,
  input  logic        s_gnt_i,
  output logic [31:0] s_addr_o,
  output logic        s_we_o,
  output logic [3:0]  s_be_o,
  output logic [31:0] s_wdata_o,
  input  logic        s_rvalid_i,
  input  logic [31:0] s_rdata_i,
  output logic        illegal_memory_o
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

  // ID FIFO: one entry per granted transfer, {master id, locally-errored flag}
  logic             fifo_id_q  [MAX_OUTSTANDING];
  logic             fifo_err_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic        fifo_full;
  logic        fifo_empty;
  logic        elig0;
  logic        elig1;
  logic        win_valid;
  logic        win_id;
  logic [31:0] win_addr;
  logic        win_we;
  logic [3:0]  win_be;
  logic [31:0] win_wdata;
  logic        in_window;
  logic        win_gnt;
  logic        head_id;
  logic        head_err;
  logic        pop;
  logic [31:0] resp_data;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(MAX_OUTSTANDING - 1)) begin
      ptr_next = '0;
    end else begin
      ptr_next = p + PTR_W'(1);
    end
  endfunction

  assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (count_q == '0);

  // A full FIFO blocks new grants even when a pop happens in the same cycle.
  // The bus is idle while in reset.
  assign elig0 = rst_ni & m0_req_i & ~fifo_full;
  assign elig1 = rst_ni & m1_req_i & ~fifo_full;

  assign win_valid = elig0 | elig1;

`ifdef OBI_ARB_RR_EN
  // prio_q names the master that wins contention (0 -> master 0)
  logic prio_q;

  assign win_id = (elig0 & elig1) ? prio_q : ~elig0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q <= 1'b0;
    end else if (win_gnt) begin
      prio_q <= ~win_id;
    end
  end
`else
  assign win_id = ~elig0;
`endif

  // Winner's address phase, zeroed when nobody is eligible
  always_comb begin
    win_addr  = '0;
    win_we    = 1'b0;
    win_be    = '0;
    win_wdata = '0;
    if (win_valid) begin
      if (win_id) begin
        win_addr  = m1_addr_i;
        win_we    = m1_we_i;
        win_be    = m1_be_i;
        win_wdata = m1_wdata_i;
      end else begin
        win_addr  = m0_addr_i;
        win_we    = m0_we_i;
        win_be    = m0_be_i;
        win_wdata = m0_wdata_i;
      end
    end
  end

  assign in_window = (win_addr >= SRAM_BASE_ADDR) && (win_addr < SRAM_END_ADDR);

  assign s_req_o   = win_valid & in_window;
  assign s_addr_o  = win_addr;
  assign s_we_o    = win_we;
  assign s_be_o    = win_be;
  assign s_wdata_o = win_wdata;

  // Out-of-window requests are accepted locally without touching the SRAM
  assign illegal_memory_o = win_valid & ~in_window;
  assign win_gnt          = win_valid & (in_window ? s_gnt_i : 1'b1);

  assign m0_gnt_o = win_gnt & ~win_id;
  assign m1_gnt_o = win_gnt &  win_id;

  // Response side. An errored head needs no SRAM response and retires as soon
  // as it reaches the head. s_rvalid_i is ignored while the head is errored.
  assign head_id   = fifo_id_q[rd_ptr_q];
  assign head_err  = fifo_err_q[rd_ptr_q];
  assign pop       = ~fifo_empty & (head_err | s_rvalid_i);
  assign resp_data = head_err ? ERR_RDATA : s_rdata_i;

  assign m0_rvalid_o = pop & ~head_id;
  assign m1_rvalid_o = pop &  head_id;
  assign m0_rdata_o  = m0_rvalid_o ? resp_data : 32'h0;
  assign m1_rdata_o  = m1_rvalid_o ? resp_data : 32'h0;
  assign m0_err_o    = m0_rvalid_o & head_err;
  assign m1_err_o    = m1_rvalid_o & head_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
        fifo_id_q[i]  <= 1'b0;
        fifo_err_q[i] <= 1'b0;
      end
    end else begin
      if (win_gnt) begin
        fifo_id_q[wr_ptr_q]  <= win_id;
        fifo_err_q[wr_ptr_q] <= ~in_window;
        wr_ptr_q             <= ptr_next(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_next(rd_ptr_q);
      end
      case ({win_gnt, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
